// File: rtl/dispatcher_pkg.sv
// Shared widths, opcode enum and operand record for the dispatch front-end.
// Imported by the interface, the operand resolver and the dispatcher top.
package dispatcher_pkg;

   localparam int unsigned DATA_LEN     = 32;
   localparam int unsigned ROB_LEN      = 4;
   localparam int unsigned OPENUM_LEN   = 6;
   localparam int unsigned REG_NUM      = 32;
   localparam int unsigned REG_ADDR_LEN = 5;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   typedef enum logic [OPENUM_LEN-1:0] {
      OpNop  = 6'd0,
      OpAdd  = 6'd1,
      OpAddi = 6'd2,
      OpSub  = 6'd3,
      OpBeq  = 6'd4,
      OpSw   = 6'd5,
      OpLw   = 6'd6
   } openum_e;

   typedef logic [DATA_LEN-1:0]     data_t;
   typedef logic [ROB_LEN-1:0]      rob_id_t;
   typedef logic [REG_ADDR_LEN-1:0] reg_addr_t;

   // Resolved source: q == 0 means v holds the value, otherwise wait on ROB tag q.
   typedef struct packed {
      data_t   v;
      rob_id_t q;
   } operand_t;

   function automatic logic tag_hit(input logic valid, input rob_id_t id, input rob_id_t tag);
      return valid && (id == tag);
   endfunction

endpackage

// File: rtl/dispatcher_if.sv
// Decoder-to-dispatcher instruction handshake and dispatcher-to-RS issue slot.
// master = dispatcher side, slave = decoder/RS environment side.
interface dispatcher_if;
   import dispatcher_pkg::*;

   logic                  inst_valid;
   logic                  inst_ready;
   logic [OPENUM_LEN-1:0] inst_openum;
   reg_addr_t             inst_rd;
   reg_addr_t             inst_rs1;
   reg_addr_t             inst_rs2;
   data_t                 inst_imm;
   data_t                 inst_pc;

   logic                  rs_full;
   logic                  rs_valid;
   logic [OPENUM_LEN-1:0] rs_openum;
   data_t                 rs_V1;
   data_t                 rs_V2;
   rob_id_t               rs_Q1;
   rob_id_t               rs_Q2;
   data_t                 rs_pc;
   data_t                 rs_imm;
   rob_id_t               rs_rob_id;

   modport master (
      input  inst_valid, inst_openum, inst_rd, inst_rs1, inst_rs2, inst_imm, inst_pc, rs_full,
      output inst_ready, rs_valid, rs_openum, rs_V1, rs_V2, rs_Q1, rs_Q2, rs_pc, rs_imm,
             rs_rob_id
   );

   modport slave (
      output inst_valid, inst_openum, inst_rd, inst_rs1, inst_rs2, inst_imm, inst_pc, rs_full,
      input  inst_ready, rs_valid, rs_openum, rs_V1, rs_V2, rs_Q1, rs_Q2, rs_pc, rs_imm,
             rs_rob_id
   );

endinterface

// File: rtl/dispatcher_operand_resolver.sv
// Combinational source operand resolution: x0, register file, CDB, commit bypass, ROB,
// else wait on the pending tag. Earlier sources take priority.
module dispatcher_operand_resolver
   import dispatcher_pkg::*;
(
   input  reg_addr_t i_rs,
   input  rob_id_t   i_tag,
   input  data_t     i_rf_rdata,
   input  logic      i_cdb_valid,
   input  rob_id_t   i_cdb_rob_id,
   input  data_t     i_cdb_value,
   input  logic      i_commit_valid,
   input  rob_id_t   i_commit_rob_id,
   input  data_t     i_commit_value,
   input  logic      i_qry_ready,
   input  data_t     i_qry_value,
   output operand_t  o_op
);

   always_comb begin
      o_op = '0;
      if (i_rs == '0) begin
         o_op = '0;
      end else if (i_tag == '0) begin
         o_op.v = i_rf_rdata;
      end else if (tag_hit(i_cdb_valid, i_cdb_rob_id, i_tag)) begin
         o_op.v = i_cdb_value;
      end else if (tag_hit(i_commit_valid, i_commit_rob_id, i_tag)) begin
         o_op.v = i_commit_value;
      end else if (i_qry_ready) begin
         o_op.v = i_qry_value;
      end else begin
         o_op.q = i_tag;
      end
   end

endmodule

// File: rtl/dispatcher.sv
// Dispatch stage: renames rd to a fresh ROB tag, resolves sources and registers one
// issue slot for the reservation station. Owns the register rename table.
module dispatcher
   import dispatcher_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_flush,

   dispatcher_if.master bus,

   output reg_addr_t  o_rf_raddr1,
   output reg_addr_t  o_rf_raddr2,
   input  data_t      i_rf_rdata1,
   input  data_t      i_rf_rdata2,

   input  logic       i_rob_full,
   input  rob_id_t    i_rob_free_id,
   output logic       o_rob_alloc,
   output rob_id_t    o_rob_qry1_id,
   output rob_id_t    o_rob_qry2_id,
   input  logic       i_rob_qry1_ready,
   input  logic       i_rob_qry2_ready,
   input  data_t      i_rob_qry1_value,
   input  data_t      i_rob_qry2_value,

   input  logic       i_cdb_valid,
   input  rob_id_t    i_cdb_rob_id,
   input  data_t      i_cdb_value,

   input  logic       i_commit_valid,
   input  reg_addr_t  i_commit_rd,
   input  rob_id_t    i_commit_rob_id,
   input  data_t      i_commit_value
);

   rob_id_t               r_tag [REG_NUM];
   logic                  w_dispatch;
   rob_id_t               w_tag1;
   rob_id_t               w_tag2;
   operand_t              w_op1;
   operand_t              w_op2;

   logic                  r_rs_valid;
   logic [OPENUM_LEN-1:0] r_rs_openum;
   operand_t              r_rs_op1;
   operand_t              r_rs_op2;
   data_t                 r_rs_pc;
   data_t                 r_rs_imm;
   rob_id_t               r_rs_rob_id;

   assign bus.inst_ready = !bus.rs_full && !i_rob_full && !i_flush;
   assign w_dispatch     = bus.inst_valid && bus.inst_ready;
   assign o_rob_alloc    = w_dispatch;

   // Sources see the table before this instruction's own rename.
   assign w_tag1        = r_tag[bus.inst_rs1];
   assign w_tag2        = r_tag[bus.inst_rs2];
   assign o_rf_raddr1   = bus.inst_rs1;
   assign o_rf_raddr2   = bus.inst_rs2;
   assign o_rob_qry1_id = w_tag1;
   assign o_rob_qry2_id = w_tag2;

   dispatcher_operand_resolver u_res1 (
      .i_rs            (bus.inst_rs1),
      .i_tag           (w_tag1),
      .i_rf_rdata      (i_rf_rdata1),
      .i_cdb_valid     (i_cdb_valid),
      .i_cdb_rob_id    (i_cdb_rob_id),
      .i_cdb_value     (i_cdb_value),
      .i_commit_valid  (i_commit_valid),
      .i_commit_rob_id (i_commit_rob_id),
      .i_commit_value  (i_commit_value),
      .i_qry_ready     (i_rob_qry1_ready),
      .i_qry_value     (i_rob_qry1_value),
      .o_op            (w_op1)
   );

   dispatcher_operand_resolver u_res2 (
      .i_rs            (bus.inst_rs2),
      .i_tag           (w_tag2),
      .i_rf_rdata      (i_rf_rdata2),
      .i_cdb_valid     (i_cdb_valid),
      .i_cdb_rob_id    (i_cdb_rob_id),
      .i_cdb_value     (i_cdb_value),
      .i_commit_valid  (i_commit_valid),
      .i_commit_rob_id (i_commit_rob_id),
      .i_commit_value  (i_commit_value),
      .i_qry_ready     (i_rob_qry2_ready),
      .i_qry_value     (i_rob_qry2_value),
      .o_op            (w_op2)
   );

   // Commit clear is written first so a same-cycle rename of the same rd overrides it.
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         for (int unsigned i = 0; i < REG_NUM; i++) begin
            r_tag[i] <= '0;
         end
      end else begin
         if (i_commit_valid && (i_commit_rd != '0) && (r_tag[i_commit_rd] == i_commit_rob_id)) begin
            r_tag[i_commit_rd] <= '0;
         end
         if (w_dispatch && (bus.inst_rd != '0)) begin
            r_tag[bus.inst_rd] <= i_rob_free_id;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rs_valid  <= FALSE;
         r_rs_openum <= '0;
         r_rs_op1    <= '0;
         r_rs_op2    <= '0;
         r_rs_pc     <= '0;
         r_rs_imm    <= '0;
         r_rs_rob_id <= '0;
      end else if (i_flush) begin
         r_rs_valid <= FALSE;
      end else begin
         r_rs_valid <= w_dispatch;
         if (w_dispatch) begin
            r_rs_openum <= bus.inst_openum;
            r_rs_op1    <= w_op1;
            r_rs_op2    <= w_op2;
            r_rs_pc     <= bus.inst_pc;
            r_rs_imm    <= bus.inst_imm;
            r_rs_rob_id <= i_rob_free_id;
         end
      end
   end

   assign bus.rs_valid  = r_rs_valid;
   assign bus.rs_openum = r_rs_openum;
   assign bus.rs_V1     = r_rs_op1.v;
   assign bus.rs_Q1     = r_rs_op1.q;
   assign bus.rs_V2     = r_rs_op2.v;
   assign bus.rs_Q2     = r_rs_op2.q;
   assign bus.rs_pc     = r_rs_pc;
   assign bus.rs_imm    = r_rs_imm;
   assign bus.rs_rob_id = r_rs_rob_id;

endmodule

// File: tb/tb_dispatcher.sv
// Directed bench for dispatcher: a rename-table model predicts every cycle's outputs,
// and hand-computed literals pin the key scenarios.
module tb_dispatcher;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic [4:0]  rf_raddr1, rf_raddr2;
   logic [31:0] rf_rdata1 = 0, rf_rdata2 = 0;
   logic        rob_full = 1'b0;
   logic [3:0]  rob_free_id = 4'd1;
   logic        rob_alloc;
   logic [3:0]  rob_qry1_id, rob_qry2_id;
   logic        rob_qry1_ready = 1'b0, rob_qry2_ready = 1'b0;
   logic [31:0] rob_qry1_value = 0, rob_qry2_value = 0;
   logic        cdb_valid = 1'b0;
   logic [3:0]  cdb_rob_id = 0;
   logic [31:0] cdb_value = 0;
   logic        commit_valid = 1'b0;
   logic [4:0]  commit_rd = 0;
   logic [3:0]  commit_rob_id = 0;
   logic [31:0] commit_value = 0;

   int n_checks = 0;
   int n_err = 0;
   bit run = 1'b0;

   dispatcher_if bus ();

   dispatcher dut (
      .clk              (clk),
      .rst              (rst),
      .i_flush          (flush),
      .bus              (bus),
      .o_rf_raddr1      (rf_raddr1),
      .o_rf_raddr2      (rf_raddr2),
      .i_rf_rdata1      (rf_rdata1),
      .i_rf_rdata2      (rf_rdata2),
      .i_rob_full       (rob_full),
      .i_rob_free_id    (rob_free_id),
      .o_rob_alloc      (rob_alloc),
      .o_rob_qry1_id    (rob_qry1_id),
      .o_rob_qry2_id    (rob_qry2_id),
      .i_rob_qry1_ready (rob_qry1_ready),
      .i_rob_qry2_ready (rob_qry2_ready),
      .i_rob_qry1_value (rob_qry1_value),
      .i_rob_qry2_value (rob_qry2_value),
      .i_cdb_valid      (cdb_valid),
      .i_cdb_rob_id     (cdb_rob_id),
      .i_cdb_value      (cdb_value),
      .i_commit_valid   (commit_valid),
      .i_commit_rd      (commit_rd),
      .i_commit_rob_id  (commit_rob_id),
      .i_commit_value   (commit_value)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Model state: architectural tag table and the expected issue slot.
   int          m_tag [32];
   bit          m_valid = 1'b0;
   logic [5:0]  m_openum = 0;
   logic [31:0] m_v1 = 0, m_v2 = 0, m_pc = 0, m_imm = 0;
   int          m_q1 = 0, m_q2 = 0, m_rob = 0;

   // Returns {value, tag}: value known -> tag 0, otherwise value 0 and the pending tag.
   function automatic logic [35:0] resolve(input int rs, input logic [31:0] rf,
                                           input logic rdy, input logic [31:0] qv);
      int t;
      if (rs == 0) return 36'd0;
      t = m_tag[rs];
      if (t == 0) return {rf, 4'd0};
      if (cdb_valid && int'(cdb_rob_id) == t) return {cdb_value, 4'd0};
      if (commit_valid && int'(commit_rob_id) == t) return {commit_value, 4'd0};
      if (rdy) return {qv, 4'd0};
      return {32'd0, 4'(t)};
   endfunction

   initial begin
      logic [35:0] o1, o2;
      bit disp;
      foreach (m_tag[i]) m_tag[i] = 0;
      forever begin
         @(posedge clk);
         if (rst) begin
            foreach (m_tag[i]) m_tag[i] = 0;
            m_valid = 0; m_openum = 0; m_v1 = 0; m_v2 = 0; m_q1 = 0; m_q2 = 0;
            m_pc = 0; m_imm = 0; m_rob = 0;
         end else if (flush) begin
            foreach (m_tag[i]) m_tag[i] = 0;
            m_valid = 0;
         end else begin
            disp = bus.inst_valid && !bus.rs_full && !rob_full;
            m_valid = disp;
            if (disp) begin
               o1 = resolve(int'(bus.inst_rs1), rf_rdata1, rob_qry1_ready, rob_qry1_value);
               o2 = resolve(int'(bus.inst_rs2), rf_rdata2, rob_qry2_ready, rob_qry2_value);
               m_v1 = o1[35:4]; m_q1 = int'(o1[3:0]);
               m_v2 = o2[35:4]; m_q2 = int'(o2[3:0]);
               m_openum = bus.inst_openum; m_pc = bus.inst_pc; m_imm = bus.inst_imm;
               m_rob = int'(rob_free_id);
            end
            if (commit_valid && commit_rd != 0 && m_tag[commit_rd] == int'(commit_rob_id))
               m_tag[commit_rd] = 0;
            if (disp && bus.inst_rd != 0) m_tag[bus.inst_rd] = int'(rob_free_id);
         end
      end
   end

   // Per-cycle compare against the model, away from the active edge.
   initial begin
      wait (run);
      forever begin
         @(negedge clk);
         chk("inst_ready", 32'(bus.inst_ready), 32'(!bus.rs_full && !rob_full && !flush));
         chk("rob_alloc", 32'(rob_alloc),
             32'(bus.inst_valid && !bus.rs_full && !rob_full && !flush));
         chk("rf_raddr1", 32'(rf_raddr1), 32'(bus.inst_rs1));
         chk("rf_raddr2", 32'(rf_raddr2), 32'(bus.inst_rs2));
         chk("rob_qry1_id", 32'(rob_qry1_id), 32'(m_tag[bus.inst_rs1]));
         chk("rob_qry2_id", 32'(rob_qry2_id), 32'(m_tag[bus.inst_rs2]));
         chk("rs_valid", 32'(bus.rs_valid), 32'(m_valid));
         if (m_valid) begin
            chk("rs_openum", 32'(bus.rs_openum), 32'(m_openum));
            chk("rs_V1", bus.rs_V1, m_v1);
            chk("rs_Q1", 32'(bus.rs_Q1), 32'(m_q1));
            chk("rs_V2", bus.rs_V2, m_v2);
            chk("rs_Q2", 32'(bus.rs_Q2), 32'(m_q2));
            chk("rs_pc", bus.rs_pc, m_pc);
            chk("rs_imm", bus.rs_imm, m_imm);
            chk("rs_rob_id", 32'(bus.rs_rob_id), 32'(m_rob));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic inst(input bit v, input logic [5:0] op, input int rd, input int rs1,
                       input int rs2, input logic [31:0] imm, input logic [31:0] pc);
      bus.inst_valid = v; bus.inst_openum = op; bus.inst_rd = 5'(rd);
      bus.inst_rs1 = 5'(rs1); bus.inst_rs2 = 5'(rs2); bus.inst_imm = imm; bus.inst_pc = pc;
   endtask

   initial begin
      bus.rs_full = 1'b0;
      inst(0, 6'd0, 0, 0, 0, 0, 0);
      tick(); tick();
      chk("reset rs_valid", 32'(bus.rs_valid), 32'd0);
      chk("reset rs_V1", bus.rs_V1, 32'd0);
      chk("reset rs_rob_id", 32'(bus.rs_rob_id), 32'd0);
      rst = 1'b0;
      run = 1'b1;

      // add x5, x1, x2 with clean table
      inst(1, 6'd1, 5, 1, 2, 32'h0, 32'h100);
      rf_rdata1 = 10; rf_rdata2 = 20; rob_free_id = 3;
      #1;
      chk("add rob_alloc", 32'(rob_alloc), 32'd1);
      tick();
      inst(0, 6'd0, 0, 5, 0, 0, 0);
      chk("add rs_valid", 32'(bus.rs_valid), 32'd1);
      chk("add V1", bus.rs_V1, 32'd10);
      chk("add V2", bus.rs_V2, 32'd20);
      chk("add Q1", 32'(bus.rs_Q1), 32'd0);
      chk("add rob_id", 32'(bus.rs_rob_id), 32'd3);
      chk("model tag5", 32'(m_tag[5]), 32'd3);
      #1;
      chk("tag5 is 3", 32'(rob_qry1_id), 32'd3);

      // x5 pending, x0 as rs2 must read 0 even with nonzero rf data
      inst(1, 6'd3, 0, 5, 0, 0, 32'h104);
      tick();
      chk("pend Q1", 32'(bus.rs_Q1), 32'd3);
      chk("pend V1", bus.rs_V1, 32'd0);
      chk("x0 V2", bus.rs_V2, 32'd0);

      inst(1, 6'd3, 0, 5, 0, 0, 32'h108);
      cdb_valid = 1; cdb_rob_id = 3; cdb_value = 77;
      tick();
      cdb_valid = 0;
      chk("cdb V1", bus.rs_V1, 32'd77);
      chk("cdb Q1", 32'(bus.rs_Q1), 32'd0);

      commit_valid = 1; commit_rd = 9; commit_rob_id = 3; commit_value = 66;
      tick();
      commit_valid = 0;
      chk("commit bypass V1", bus.rs_V1, 32'd66);

      rob_qry1_ready = 1; rob_qry1_value = 55;
      tick();
      rob_qry1_ready = 0;
      chk("rob ready V1", bus.rs_V1, 32'd55);

      // addi x5, x5, 1 renames x5 from 3 to 4
      inst(1, 6'd2, 5, 5, 0, 32'd1, 32'h110);
      rob_free_id = 4;
      tick();
      inst(0, 6'd0, 0, 5, 0, 0, 0);
      chk("addi Q1", 32'(bus.rs_Q1), 32'd3);
      chk("addi imm", bus.rs_imm, 32'd1);
      chk("addi rob_id", 32'(bus.rs_rob_id), 32'd4);

      // stale commit leaves the newer tag in place
      commit_valid = 1; commit_rd = 5; commit_rob_id = 3; commit_value = 33;
      tick();
      commit_valid = 0;
      #1;
      chk("stale commit tag5", 32'(rob_qry1_id), 32'd4);

      // matching commit races with a rename of x5 to 6: rename wins
      inst(1, 6'd1, 5, 5, 0, 0, 32'h114);
      rob_free_id = 6;
      commit_valid = 1; commit_rd = 5; commit_rob_id = 4; commit_value = 44;
      tick();
      commit_valid = 0;
      inst(1, 6'd1, 8, 5, 0, 0, 32'h118);
      rob_free_id = 7;
      chk("race V1", bus.rs_V1, 32'd44);
      #1;
      chk("race tag5", 32'(rob_qry1_id), 32'd6);
      tick();
      inst(0, 6'd0, 0, 0, 0, 0, 0);
      chk("back-to-back valid", 32'(bus.rs_valid), 32'd1);
      chk("back-to-back Q1", 32'(bus.rs_Q1), 32'd6);

      // stalls: rs_full then rob_full
      inst(1, 6'd1, 7, 7, 0, 0, 32'h11c);
      rob_free_id = 9;
      bus.rs_full = 1;
      #1;
      chk("rs_full ready", 32'(bus.inst_ready), 32'd0);
      chk("rs_full alloc", 32'(rob_alloc), 32'd0);
      tick();
      chk("rs_full no slot", 32'(bus.rs_valid), 32'd0);
      bus.rs_full = 0; rob_full = 1;
      #1;
      chk("rob_full alloc", 32'(rob_alloc), 32'd0);
      tick();
      rob_full = 0;
      chk("rob_full no slot", 32'(bus.rs_valid), 32'd0);
      chk("stall tag7", 32'(rob_qry1_id), 32'd0);

      // set x7, then flush with an instruction waiting
      inst(1, 6'd1, 7, 0, 0, 0, 32'h120);
      rob_free_id = 10;
      tick();
      inst(1, 6'd1, 9, 5, 7, 0, 32'h124);
      flush = 1;
      #1;
      chk("flush alloc", 32'(rob_alloc), 32'd0);
      tick();
      flush = 0;
      chk("flush no slot", 32'(bus.rs_valid), 32'd0);
      rf_rdata1 = 123; rf_rdata2 = 456; rob_free_id = 11;
      tick();
      inst(0, 6'd0, 0, 0, 0, 0, 0);
      chk("post-flush Q1", 32'(bus.rs_Q1), 32'd0);
      chk("post-flush V1", bus.rs_V1, 32'd123);
      chk("post-flush V2", bus.rs_V2, 32'd456);
      tick(); tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/dispatcher.md
# dispatcher

Front-end stage that feeds the reservation station. Each cycle it accepts at most one decoded instruction and renames its destination to a freshly allocated ROB tag. It resolves source operands to either values or pending ROB tags from the register file, ROB, CDB and commit bypass, then presents one registered issue slot to the RS. It owns the register rename table (tag per architectural register) and is the writer side of the RS dispatch interface.

## Interface
- `DATA_LEN`, 32, operand/immediate/pc width
- `ROB_LEN`, 4, ROB tag width; tag 0 = "no dependency", valid tags 1..2^ROB_LEN-1
- `OPENUM_LEN`, 6, opcode enum width
- `REG_NUM`, 32, architectural registers (x0 hardwired zero)
- `clk` in 1 clock
- `rst` in 1 reset, synchronous, active-high
- `flush` in 1 mispredict rollback
- `inst_valid` in 1 decoder has instruction
- `inst_ready` out 1 dispatcher accepts this cycle
- `inst_openum` in OPENUM_LEN; `inst_rd`, `inst_rs1`, `inst_rs2` in 5; `inst_imm` in DATA_LEN; `inst_pc` in DATA_LEN
- `rf_raddr1`, `rf_raddr2` out 5; `rf_rdata1`, `rf_rdata2` in DATA_LEN (combinational read)
- `rob_full` in 1; `rob_free_id` in ROB_LEN (next tag, never 0); `rob_alloc` out 1
- `rob_qry1_id`, `rob_qry2_id` out ROB_LEN; `rob_qry1_ready`, `rob_qry2_ready` in 1; `rob_qry1_value`, `rob_qry2_value` in DATA_LEN
- `cdb_valid` in 1; `cdb_rob_id` in ROB_LEN; `cdb_value` in DATA_LEN
- `commit_valid` in 1; `commit_rd` in 5; `commit_rob_id` in ROB_LEN; `commit_value` in DATA_LEN
- `rs_full` in 1
- `rs_valid` out 1; `rs_openum` out OPENUM_LEN; `rs_V1`, `rs_V2` out DATA_LEN; `rs_Q1`, `rs_Q2` out ROB_LEN; `rs_pc`, `rs_imm` out DATA_LEN; `rs_rob_id` out ROB_LEN

## Operation
- `inst_ready = !rs_full && !rob_full && !flush`. Dispatch = `inst_valid && inst_ready`. `rob_alloc` = dispatch (combinational).
- Rename table `tag[REG_NUM]`; `tag[0]` is always 0.
- Operand n (n = 1, 2) resolution, first match wins:
  - `rsn == 0` → V=0, Q=0.
  - `tag[rsn] == 0` → V=`rf_rdatan`, Q=0.
  - `cdb_valid` and `cdb_rob_id == tag` → V=`cdb_value`, Q=0.
  - `commit_valid` and `commit_rob_id == tag` → V=`commit_value`, Q=0.
  - `rob_qryn_ready` → V=`rob_qryn_value`, Q=0.
  - Otherwise V=0, Q=tag.
- Query outputs are combinational: `rf_raddrn = inst_rsn`, `rob_qryn_id = tag[inst_rsn]`.
- Sources read the tag table before the current instruction's rename, so `rs1 == rd` yields the old tag.
- On dispatch with `rd != 0`: `tag[rd] <= rob_free_id`. `rd == 0` (branches, stores) performs no rename.
- On commit: if `tag[commit_rd] == commit_rob_id`, clear it to 0. Dispatch rename of the same rd in the same cycle wins.
- On flush: all tags ← 0; `rs_valid` ← 0 next cycle; no dispatch in the flush cycle.
- CDB results arriving in or after the cycle `rs_valid` is high are snooped by the RS, not by the dispatcher.

## Timing
- Reset: all tags 0; `rs_valid` 0; all `rs_*` data outputs 0.
- Latency: a dispatch in cycle t drives `rs_valid = 1` with all fields in cycle t+1, for exactly one cycle per dispatch.
- Back-to-back dispatches produce consecutive `rs_valid` cycles.
- `rs_full` and `rob_full` are sampled in the dispatch cycle only. The RS must accept any slot presented while it reported not-full in the prior cycle.
- `rst` takes priority over `flush`. Both take priority over dispatch and commit.

## Structure
- Shared defines (`DATA_LEN`, `ROB_LEN`, `OPENUM_LEN`, `TRUE`/`FALSE`, opcode enums) live in the common defines header.
- One sub-module, `operand_resolver`: purely combinational, instantiated twice (rs1, rs2). Implements the priority list above.
- The rename table and output register stay in `dispatcher`.

## Test plan
- Reset, then `add rd=5, rs1=1, rs2=2` with all tags 0, `rf_rdata1=10`, `rf_rdata2=20`, `rob_free_id=3` → next cycle `rs_valid=1`, V1=10, V2=20, Q1=Q2=0, `rs_rob_id=3`; `tag[5]=3`.
- Next instruction uses rs1=5, ROB not ready, no CDB → Q1=3, V1=0. Repeat with `cdb_valid`, `cdb_rob_id=3`, `cdb_value=77` in the dispatch cycle → V1=77, Q1=0.
- `addi x5, x5, 1` with `tag[5]=3`, `rob_free_id=4` → Q1=3; afterwards `tag[5]=4`.
- Commit rd=5 id 3 while `tag[5]=4` → tag stays 4. Commit id 4 concurrent with a dispatch renaming x5 to 6 → `tag[5]=6`.
- `rs_full=1` with `inst_valid=1` → `inst_ready=0`, `rob_alloc=0`, no `rs_valid`, tags unchanged. Repeat with `rob_full=1` → same.
- Set tags 5 and 7, assert `flush` with `inst_valid=1` → no dispatch; next instruction reading x5 gets Q1=0 from the register file.
